pipe_ctrl: RTL and testbench

Central pipeline controller for the five-stage core (IF, ID, EX, MEM, WB). Every cycle it drives per-stage stall and flush vectors and a PC redirect. It resolves four conditions by fixed priority:

- load-use hazards at ID;
- taken branches resolved in EX;
- multi-cycle mul/div operations holding EX;
- data-memory accesses waiting for acknowledge in MEM.

It also keeps a memory-wait watchdog and a saturating stall-cycle counter.

---
 rtl/pipe_ctrl.sv | 90 +++++++++
 tb/tb_pipe_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage stall/flush/redirect controller with memory watchdog and stall counter
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           id_rs1_addr_i,
  input  logic                 id_rs1_ren_i,
  input  logic [4:0]           id_rs2_addr_i,
  input  logic                 id_rs2_ren_i,
  input  logic                 ex_rmem_en_i,
  input  logic [4:0]           ex_wreg_addr_i,
  input  logic                 ex_branch_i,
  input  logic [31:0]          ex_branch_target_i,
  input  logic                 ex_md_start_i,
  input  logic                 md_done_i,
  input  logic                 mem_req_i,
  input  logic                 mem_ack_i,
  output logic [4:0]           stall_o,
  output logic [4:0]           flush_o,
  output logic                 pc_redirect_o,
  output logic [31:0]          pc_redirect_addr_o,
  output logic                 mem_timeout_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, MD_WAIT} state_t;
  state_t state, state_nx, rel_state;
  logic [7:0] timer, timer_nx;
  logic mem_hold, md_hold, lu_hit, expire, rel_redirect;
  logic [4:0] rel_stall, rel_flush;
  // Rules below the memory hold: mul/div, branch, load-use, idle
  always_comb begin
    mem_hold     = mem_req_i && !mem_ack_i;
    md_hold      = ex_md_start_i && !md_done_i;
    lu_hit       = ex_rmem_en_i && ex_wreg_addr_i != 5'd0 &&
                   ((id_rs1_ren_i && id_rs1_addr_i == ex_wreg_addr_i) ||
                    (id_rs2_ren_i && id_rs2_addr_i == ex_wreg_addr_i));
    rel_stall    = md_hold ? 5'b00111 : (lu_hit && !ex_branch_i) ? 5'b00011 : 5'b00000;
    rel_flush    = md_hold ? 5'b01000 : ex_branch_i ? 5'b00011 : lu_hit ? 5'b00100 : 5'b00000;
    rel_redirect = !md_hold && ex_branch_i;
    rel_state    = md_hold ? MD_WAIT : RUN;
    expire       = timer == 8'(MEM_TIMEOUT - 1);
  end
  // The timer also counts the RUN cycle that entered MEM_WAIT
  always_comb begin
    stall_o       = rel_stall;
    flush_o       = rel_flush;
    pc_redirect_o = rel_redirect;
    mem_timeout_o = 1'b0;
    state_nx      = rel_state;
    timer_nx      = 8'd0;
    if (rst) begin
      stall_o       = 5'b00000;
      flush_o       = 5'b11111;
      pc_redirect_o = 1'b0;
      state_nx      = RUN;
    end else if (state == MEM_WAIT && !mem_ack_i) begin
      stall_o       = expire ? 5'b00000 : 5'b01111;
      flush_o       = expire ? 5'b11000 : 5'b10000;
      pc_redirect_o = 1'b0;
      mem_timeout_o = expire;
      state_nx      = expire ? RUN : MEM_WAIT;
      timer_nx      = expire ? 8'd0 : timer + 8'd1;
    end else if (state == MD_WAIT && !md_done_i) begin
      stall_o       = 5'b00111;
      flush_o       = 5'b01000;
      pc_redirect_o = 1'b0;
      state_nx      = MD_WAIT;
    end else if (mem_hold) begin
      stall_o       = 5'b01111;
      flush_o       = 5'b10000;
      pc_redirect_o = 1'b0;
      state_nx      = MEM_WAIT;
      timer_nx      = 8'd1;
    end
  end
  assign pc_redirect_addr_o = pc_redirect_o ? ex_branch_target_i : 32'd0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      timer       <= 8'd0;
      stall_cnt_o <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      if (stall_o != 5'd0 && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_pipe_ctrl;
  logic clk = 0, rst = 1;
  logic [4:0] rs1, rs2, wreg;
  logic r1en, r2en, ld, br, md, mdd, req, ack;
  logic [31:0] tgt;
  logic [4:0] stall, flush;
  logic redir, tmo;
  logic [31:0] raddr;
  logic [3:0] cnt;
  int checks = 0, fails = 0;
  logic [47:0] eq[$];
  string nq[$];
  pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr_i(rs1), .id_rs1_ren_i(r1en), .id_rs2_addr_i(rs2), .id_rs2_ren_i(r2en),
    .ex_rmem_en_i(ld), .ex_wreg_addr_i(wreg), .ex_branch_i(br), .ex_branch_target_i(tgt),
    .ex_md_start_i(md), .md_done_i(mdd), .mem_req_i(req), .mem_ack_i(ack),
    .stall_o(stall), .flush_o(flush), .pc_redirect_o(redir), .pc_redirect_addr_o(raddr),
    .mem_timeout_o(tmo), .stall_cnt_o(cnt)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set(input logic [4:0] a1, input logic e1, input logic [4:0] a2, input logic e2,
                     input logic l, input logic [4:0] w, input logic b, input logic [31:0] t,
                     input logic m, input logic d, input logic rq, input logic ak);
    rs1 = a1; r1en = e1; rs2 = a2; r2en = e2; ld = l; wreg = w;
    br = b; tgt = t; md = m; mdd = d; req = rq; ack = ak;
  endtask
  task automatic idle();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic chk(input string nm, input logic [4:0] s, input logic [4:0] f, input logic r,
                     input logic [31:0] a, input logic t, input logic [3:0] c);
    eq.push_back({s, f, r, a, t, c});
    nq.push_back(nm);
  endtask
  always @(negedge clk) begin
    if (eq.size() > 0) begin
      logic [47:0] e, g;
      string nm;
      e = eq.pop_front();
      nm = nq.pop_front();
      g = {stall, flush, redir, raddr, tmo, cnt};
      checks++;
      if (g !== e) begin
        fails++;
        $display("FAIL %s: got stall=%b flush=%b redir=%b addr=%h tmo=%b cnt=%0d, expected stall=%b flush=%b redir=%b addr=%h tmo=%b cnt=%0d",
                 nm, g[47:43], g[42:38], g[37], g[36:5], g[4], g[3:0],
                 e[47:43], e[42:38], e[37], e[36:5], e[4], e[3:0]);
      end
    end
  end
  initial begin
    idle();
    step(); chk("reset", 5'b00000, 5'b11111, 0, 0, 0, 0);
    step(); rst = 0; idle(); chk("idle", 0, 0, 0, 0, 0, 0);
    step(); set(0, 0, 5, 1, 1, 5, 0, 0, 0, 0, 0, 0); chk("lu_rs2", 5'b00011, 5'b00100, 0, 0, 0, 0);
    step(); idle(); chk("lu_one_bubble", 0, 0, 0, 0, 0, 1);
    step(); set(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0); chk("lu_x0", 0, 0, 0, 0, 0, 1);
    step(); set(7, 1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0); chk("lu_rs1", 5'b00011, 5'b00100, 0, 0, 0, 1);
    step(); set(7, 0, 3, 1, 1, 7, 0, 0, 0, 0, 0, 0); chk("lu_noren", 0, 0, 0, 0, 0, 2);
    step(); set(0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0); chk("branch", 0, 5'b00011, 1, 32'h100, 0, 2);
    step(); set(0, 0, 5, 1, 1, 5, 1, 32'h200, 0, 0, 0, 0); chk("branch_over_lu", 0, 5'b00011, 1, 32'h200, 0, 2);
    step(); set(0, 0, 0, 0, 0, 0, 1, 32'h300, 0, 0, 1, 0); chk("memw1", 5'b01111, 5'b10000, 0, 0, 0, 2);
    step(); chk("memw2", 5'b01111, 5'b10000, 0, 0, 0, 3);
    step(); chk("memw3", 5'b01111, 5'b10000, 0, 0, 0, 4);
    step(); ack = 1; chk("memw_ack_redirect", 0, 5'b00011, 1, 32'h300, 0, 5);
    step(); set(0, 0, 5, 1, 1, 5, 0, 0, 0, 0, 1, 0); chk("mem_over_lu", 5'b01111, 5'b10000, 0, 0, 0, 5);
    step(); ack = 1; chk("lu_after_ack", 5'b00011, 5'b00100, 0, 0, 0, 6);
    step(); idle(); chk("idle2", 0, 0, 0, 0, 0, 7);
    step(); req = 1; chk("wd1", 5'b01111, 5'b10000, 0, 0, 0, 7);
    step(); chk("wd2", 5'b01111, 5'b10000, 0, 0, 0, 8);
    step(); chk("wd3", 5'b01111, 5'b10000, 0, 0, 0, 9);
    step(); chk("wd_abort", 0, 5'b11000, 0, 0, 1, 10);
    step(); idle(); chk("wd_run", 0, 0, 0, 0, 0, 10);
    for (int i = 0; i < 5; i++) begin
      step(); md = 1; mdd = 0; chk("md_hold", 5'b00111, 5'b01000, 0, 0, 0, 4'(10 + i));
    end
    step(); mdd = 1; chk("md_done", 0, 0, 0, 0, 0, 15);
    step(); idle(); chk("idle3", 0, 0, 0, 0, 0, 15);
    step(); set(0, 0, 0, 0, 0, 0, 1, 32'h400, 1, 0, 0, 0); chk("md_over_branch", 5'b00111, 5'b01000, 0, 0, 0, 15);
    step(); mdd = 1; chk("branch_after_md", 0, 5'b00011, 1, 32'h400, 0, 15);
    step(); set(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0); chk("mem_over_md", 5'b01111, 5'b10000, 0, 0, 0, 15);
    step(); ack = 1; chk("md_after_ack", 5'b00111, 5'b01000, 0, 0, 0, 15);
    step(); set(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0); chk("cnt_saturated", 0, 0, 0, 0, 0, 15);
    step(); mdd = 0; chk("md_pre_reset", 5'b00111, 5'b01000, 0, 0, 0, 15);
    step(); #2 rst = 1; chk("async_reset", 0, 5'b11111, 0, 0, 0, 0);
    step(); chk("reset_hold", 0, 5'b11111, 0, 0, 0, 0);
    step(); rst = 0; idle(); chk("run_after_reset", 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    checks++;
    if (eq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", eq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
